dmem_access_unit: RTL and testbench

Memory-stage data-bus master for the five-stage RISC-V core. It turns the M-stage load/store into a valid/ready request and a response on the data bus, and raises a stall request to the hazard logic until the access completes. It performs byte-lane steering, load extension and misalignment detection. It is the consumer side of the pipeline stall protocol: the hazard logic holds F through M while `StallMemReq` is high.

---
 rtl/dmem_access_unit_if.sv | 36 +++
 rtl/dmem_access_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-bus bundle between the M-stage access unit (master) and the data memory fabric (slave).
interface dmem_access_unit_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req_valid,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_wstrb,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_wstrb,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/dmem_access_unit.sv
// M-stage data-bus master: request sequencing, lane steering, load extension, misalignment and stall.
// Optional bus watchdog is built when DMEM_TIMEOUT_EN is defined.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [2:0]                FunctM,
    input  logic [31:0]               AddrM,
    input  logic [31:0]               StoreDataM,
    input  logic                      FlushM,
    output logic                      StallMemReq,
    output logic [31:0]               LoadDataM,
    output logic                      LoadValidM,
    output logic                      MisalignExc,
    output logic                      BusErrExc,
    dmem_access_unit_if.master        bus
);
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } memStateT;

    memStateT         stateQ;
    memStateT         stateD;
    logic [2:0]       functQ;
    logic [1:0]       offQ;
    logic             killQ;
    logic             killNext;
    logic             accessReq;
    logic             misaligned;
    logic             accessOk;
    logic             reqFire;
    logic             timeoutHit;
    logic [DataW-1:0] wdataNext;
    logic [StrbW-1:0] wstrbNext;

    // Pick the addressed byte/half out of the bus word and extend it per funct3.
    function automatic logic [DataW-1:0] extendLoad(input logic [DataW-1:0] raw,
                                                    input logic [2:0]       funct,
                                                    input logic [1:0]       off);
        logic [7:0]  byteSel;
        logic [15:0] halfSel;
        byteSel = 8'(raw >> {off, 3'b000});
        halfSel = 16'(raw >> {off[1], 4'b0000});
        case (funct)
            3'b000:  extendLoad = {{24{byteSel[7]}}, byteSel};
            3'b001:  extendLoad = {{16{halfSel[15]}}, halfSel};
            3'b100:  extendLoad = {24'd0, byteSel};
            3'b101:  extendLoad = {16'd0, halfSel};
            default: extendLoad = raw;
        endcase
    endfunction

    assign accessReq = (MemReadM | MemWriteM) & ~FlushM & ~rst;
    assign accessOk  = accessReq & ~misaligned;
    assign reqFire   = bus.bus_req_valid & bus.bus_req_ready;
    assign killNext  = killQ | FlushM;

    always_comb begin
        misaligned = 1'b0;
        case (FunctM[1:0])
            2'b01:   misaligned = AddrM[0];
            2'b10:   misaligned = |AddrM[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Store lane steering; loads carry no strobes and no data.
    always_comb begin
        wdataNext = StoreDataM;
        wstrbNext = 4'b1111;
        case (FunctM[1:0])
            2'b00: begin
                wdataNext = {4{StoreDataM[7:0]}};
                wstrbNext = 4'b0001 << AddrM[1:0];
            end
            2'b01: begin
                wdataNext = {2{StoreDataM[15:0]}};
                wstrbNext = AddrM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdataNext = StoreDataM;
                wstrbNext = 4'b1111;
            end
        endcase
        if (!MemWriteM) begin
            wdataNext = '0;
            wstrbNext = '0;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned WdogW = 10;

    logic [WdogW-1:0] wdogQ;
    logic             inBus;

    assign inBus = (stateQ == REQ) || (stateQ == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdogQ <= '0;
        end else if (inBus) begin
            wdogQ <= wdogQ + WdogW'(1);
        end else begin
            wdogQ <= '0;
        end
    end

    // Fires on the TIMEOUT-th cycle spent in REQ/WAIT.
    assign timeoutHit = inBus && (wdogQ >= WdogW'(TIMEOUT - 1));
`else
    logic [31:0] unusedTimeout;

    assign unusedTimeout = 32'(TIMEOUT);
    assign timeoutHit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state plus the two combinational pipeline-facing flags.
    always_comb begin
        stateD      = stateQ;
        StallMemReq = 1'b0;
        MisalignExc = 1'b0;
        case (stateQ)
            IDLE: begin
                MisalignExc = accessReq & misaligned;
                if (accessOk) begin
                    StallMemReq = 1'b1;
                    stateD      = REQ;
                end
            end
            REQ: begin
                StallMemReq = 1'b1;
                if (reqFire) begin
                    stateD = WAIT;
                end else if (timeoutHit) begin
                    stateD = DONE;
                end
            end
            WAIT: begin
                StallMemReq = 1'b1;
                if (bus.bus_rsp_valid) begin
                    stateD = DONE;
                end else if (timeoutHit) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Request payload, kill tracking and the DONE-cycle result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_req_valid <= 1'b0;
            bus.bus_we        <= 1'b0;
            bus.bus_addr      <= '0;
            bus.bus_wdata     <= '0;
            bus.bus_wstrb     <= '0;
            functQ            <= '0;
            offQ              <= '0;
            killQ             <= 1'b0;
            LoadDataM         <= '0;
            LoadValidM        <= 1'b0;
            BusErrExc         <= 1'b0;
        end else begin
            LoadValidM <= 1'b0;
            BusErrExc  <= 1'b0;
            case (stateQ)
                IDLE: begin
                    killQ <= 1'b0;
                    if (accessOk) begin
                        bus.bus_req_valid <= 1'b1;
                        bus.bus_we        <= MemWriteM;
                        bus.bus_addr      <= {AddrM[31:2], 2'b00};
                        bus.bus_wdata     <= wdataNext;
                        bus.bus_wstrb     <= wstrbNext;
                        functQ            <= FunctM;
                        offQ              <= AddrM[1:0];
                    end
                end
                REQ: begin
                    killQ <= killNext;
                    if (reqFire) begin
                        bus.bus_req_valid <= 1'b0;
                    end else if (timeoutHit) begin
                        bus.bus_req_valid <= 1'b0;
                        LoadDataM         <= '0;
                        BusErrExc         <= ~killNext;
                    end
                end
                WAIT: begin
                    killQ <= killNext;
                    if (bus.bus_rsp_valid) begin
                        LoadDataM  <= extendLoad(bus.bus_rdata, functQ, offQ);
                        LoadValidM <= ~bus.bus_we & ~bus.bus_err & ~killNext;
                        BusErrExc  <= bus.bus_err & ~killNext;
                    end else if (timeoutHit) begin
                        LoadDataM <= '0;
                        BusErrExc <= ~killNext;
                    end
                end
                default: begin
                    killQ <= killQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: loads, stores, misalignment, flush, reset and watchdog/hang.
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  FunctM;
    logic [31:0] AddrM;
    logic [31:0] StoreDataM;
    logic        FlushM;
    logic        StallMemReq;
    logic [31:0] LoadDataM;
    logic        LoadValidM;
    logic        MisalignExc;
    logic        BusErrExc;

    dmem_access_unit_if bus();

    dmem_access_unit #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .FunctM     (FunctM),
        .AddrM      (AddrM),
        .StoreDataM (StoreDataM),
        .FlushM     (FlushM),
        .StallMemReq(StallMemReq),
        .LoadDataM  (LoadDataM),
        .LoadValidM (LoadValidM),
        .MisalignExc(MisalignExc),
        .BusErrExc  (BusErrExc),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          failed = 0;

    int          rStalls;
    logic        rDone;
    logic        rSawReq;
    logic [31:0] rAddr;
    logic [31:0] rWdata;
    logic [3:0]  rStrb;
    logic        rWe;
    logic [31:0] rData;
    logic        rValid;
    logic        rErr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One access with a cooperative slave: ready after rdyLat cycles, response one cycle after handshake.
    task automatic runAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                             input logic err, input int rdyLat);
        logic hsPrev;
        hsPrev  = 1'b0;
        rStalls = 0;
        rDone   = 1'b0;
        rSawReq = 1'b0;
        rAddr   = '0;
        rWdata  = '0;
        rStrb   = '0;
        rWe     = 1'b0;
        rData   = '0;
        rValid  = 1'b0;
        rErr    = 1'b0;
        MemReadM      = rd;
        MemWriteM     = wr;
        FunctM        = f;
        AddrM         = a;
        StoreDataM    = sd;
        bus.bus_rdata = rdat;
        bus.bus_err   = err;
        for (int c = 0; c < 60 && !rDone; c++) begin
            bus.bus_req_ready = (c >= rdyLat);
            #1;
            if (c > 0 && !StallMemReq) begin
                rDone     = 1'b1;
                rData     = LoadDataM;
                rValid    = LoadValidM;
                rErr      = BusErrExc;
                MemReadM  = 1'b0;
                MemWriteM = 1'b0;
            end else if (StallMemReq) begin
                rStalls++;
            end
            if (bus.bus_req_valid && !rSawReq) begin
                rSawReq = 1'b1;
                rAddr   = bus.bus_addr;
                rWdata  = bus.bus_wdata;
                rStrb   = bus.bus_wstrb;
                rWe     = bus.bus_we;
            end
            bus.bus_rsp_valid = hsPrev;
            hsPrev = bus.bus_req_valid && bus.bus_req_ready;
            @(negedge clk);
        end
        bus.bus_rsp_valid = 1'b0;
        bus.bus_req_ready = 1'b0;
        check({tag, "_done"}, 32'(rDone), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit observed=expired required=finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst               = 1'b1;
        MemReadM          = 1'b1;
        MemWriteM         = 1'b0;
        FunctM            = 3'b010;
        AddrM             = 32'h0000_0101;
        StoreDataM        = '0;
        FlushM            = 1'b0;
        bus.bus_req_ready = 1'b0;
        bus.bus_rsp_valid = 1'b0;
        bus.bus_rdata     = '0;
        bus.bus_err       = 1'b0;

        // Reset state, with a misaligned load presented to show the gating.
        @(negedge clk);
        #1;
        check("rst_stall", 32'(StallMemReq), 32'd0);
        check("rst_misalign", 32'(MisalignExc), 32'd0);
        check("rst_req_valid", 32'(bus.bus_req_valid), 32'd0);
        check("rst_we", 32'(bus.bus_we), 32'd0);
        check("rst_addr", bus.bus_addr, 32'd0);
        check("rst_wdata", bus.bus_wdata, 32'd0);
        check("rst_wstrb", 32'(bus.bus_wstrb), 32'd0);
        check("rst_load_data", LoadDataM, 32'd0);
        check("rst_load_valid", 32'(LoadValidM), 32'd0);
        check("rst_bus_err", 32'(BusErrExc), 32'd0);
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // LW, minimum latency.
        runAccess("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
        check("lw_stalls", 32'(rStalls), 32'd3);
        check("lw_addr", rAddr, 32'h0000_0100);
        check("lw_we", 32'(rWe), 32'd0);
        check("lw_valid", 32'(rValid), 32'd1);
        check("lw_data", rData, 32'hDEAD_BEEF);
        check("lw_err", 32'(rErr), 32'd0);
        #1;
        check("lw_valid_pulse_end", 32'(LoadValidM), 32'd0);

        // LB / LBU at byte 3.
        runAccess("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1'b0, 0);
        check("lb_addr", rAddr, 32'h0000_0100);
        check("lb_data", rData, 32'hFFFF_FF80);
        check("lb_valid", 32'(rValid), 32'd1);
        runAccess("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1'b0, 0);
        check("lbu_data", rData, 32'h0000_0080);

        // LH / LHU upper half, with a slow ready.
        runAccess("lh", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1'b0, 3);
        check("lh_stalls", 32'(rStalls), 32'd5);
        check("lh_data", rData, 32'hFFFF_80FF);
        runAccess("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_1234, 1'b0, 0);
        check("lhu_data", rData, 32'h0000_80FF);
        runAccess("lb0", 1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'd0, 32'h80FF_1234, 1'b0, 0);
        check("lb0_data", rData, 32'h0000_0034);

        // Stores.
        runAccess("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 1'b0, 0);
        check("sh_addr", rAddr, 32'h0000_0200);
        check("sh_wdata", rWdata, 32'hABCD_ABCD);
        check("sh_wstrb", 32'(rStrb), 32'h0000_000C);
        check("sh_we", 32'(rWe), 32'd1);
        check("sh_valid", 32'(rValid), 32'd0);
        check("sh_stalls", 32'(rStalls), 32'd3);
        runAccess("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'd0, 1'b0, 0);
        check("sb_wdata", rWdata, 32'h7878_7878);
        check("sb_wstrb", 32'(rStrb), 32'h0000_0002);
        runAccess("sw", 1'b0, 1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
        check("sw_addr", rAddr, 32'h0000_0304);
        check("sw_wdata", rWdata, 32'hCAFE_F00D);
        check("sw_wstrb", 32'(rStrb), 32'h0000_000F);

        // Bus error on a load.
        runAccess("lw_err", 1'b1, 1'b0, 3'b010, 32'h0000_0108, 32'd0, 32'h1111_2222, 1'b1, 0);
        check("lw_err_valid", 32'(rValid), 32'd0);
        check("lw_err_flag", 32'(rErr), 32'd1);

        // Misaligned accesses never reach the bus.
        MemReadM  = 1'b1;
        MemWriteM = 1'b0;
        FunctM    = 3'b010;
        AddrM     = 32'h0000_0101;
        #1;
        check("mis_lw_flag", 32'(MisalignExc), 32'd1);
        check("mis_lw_stall", 32'(StallMemReq), 32'd0);
        @(negedge clk);
        #1;
        check("mis_lw_no_req", 32'(bus.bus_req_valid), 32'd0);
        MemReadM  = 1'b0;
        MemWriteM = 1'b1;
        FunctM    = 3'b001;
        AddrM     = 32'h0000_0203;
        #1;
        check("mis_sh_flag", 32'(MisalignExc), 32'd1);
        @(negedge clk);
        #1;
        check("mis_sh_no_req", 32'(bus.bus_req_valid), 32'd0);
        MemWriteM = 1'b0;
        @(negedge clk);

        // Flush during WAIT with an erroring response: completes silently.
        MemReadM          = 1'b1;
        FunctM            = 3'b010;
        AddrM             = 32'h0000_0100;
        bus.bus_req_ready = 1'b1;
        bus.bus_err       = 1'b1;
        bus.bus_rdata     = 32'h5555_AAAA;
        @(negedge clk);
        @(negedge clk);
        bus.bus_req_ready = 1'b0;
        FlushM = 1'b1;
        #1;
        check("flush_wait_stall", 32'(StallMemReq), 32'd1);
        check("flush_wait_req", 32'(bus.bus_req_valid), 32'd0);
        @(negedge clk);
        FlushM            = 1'b0;
        bus.bus_rsp_valid = 1'b1;
        @(negedge clk);
        bus.bus_rsp_valid = 1'b0;
        #1;
        check("flush_done_stall", 32'(StallMemReq), 32'd0);
        check("flush_done_valid", 32'(LoadValidM), 32'd0);
        check("flush_done_err", 32'(BusErrExc), 32'd0);
        MemReadM = 1'b0;
        @(negedge clk);
        runAccess("post_flush", 1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'h0000_0055, 1'b1, 0);
        check("post_flush_err", 32'(rErr), 32'd1);

        // FlushM in IDLE suppresses the access.
        MemReadM = 1'b1;
        FlushM   = 1'b1;
        #1;
        check("flush_idle_stall", 32'(StallMemReq), 32'd0);
        @(negedge clk);
        #1;
        check("flush_idle_no_req", 32'(bus.bus_req_valid), 32'd0);
        MemReadM = 1'b0;
        FlushM   = 1'b0;
        @(negedge clk);

        // Reset in the middle of REQ.
        MemReadM = 1'b1;
        FunctM   = 3'b010;
        AddrM    = 32'h0000_0500;
        @(negedge clk);
        #1;
        check("midrst_req_before", 32'(bus.bus_req_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_req_dropped", 32'(bus.bus_req_valid), 32'd0);
        check("midrst_stall", 32'(StallMemReq), 32'd0);
        MemReadM = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_idle_stall", 32'(StallMemReq), 32'd0);
        @(negedge clk);

`ifdef DMEM_TIMEOUT_EN
        begin : toBlk
            int vCnt;
            vCnt              = 0;
            rDone             = 1'b0;
            rErr              = 1'b0;
            rValid            = 1'b1;
            MemReadM          = 1'b1;
            FunctM            = 3'b010;
            AddrM             = 32'h0000_0400;
            bus.bus_req_ready = 1'b0;
            for (int c = 0; c < 40 && !rDone; c++) begin
                #1;
                if (bus.bus_req_valid) vCnt++;
                if (c > 0 && !StallMemReq) begin
                    rDone    = 1'b1;
                    rErr     = BusErrExc;
                    rValid   = LoadValidM;
                    MemReadM = 1'b0;
                end
                @(negedge clk);
            end
            check("to_valid_cycles", 32'(vCnt), 32'd8);
            check("to_done", 32'(rDone), 32'd1);
            check("to_bus_err", 32'(rErr), 32'd1);
            check("to_load_valid", 32'(rValid), 32'd0);
            bus.bus_rsp_valid = 1'b1;
            #1;
            check("to_idle_stall", 32'(StallMemReq), 32'd0);
            check("to_err_pulse_end", 32'(BusErrExc), 32'd0);
            @(negedge clk);
            bus.bus_rsp_valid = 1'b0;
            #1;
            check("to_late_rsp_ignored", 32'(LoadValidM), 32'd0);
            @(negedge clk);
        end
`else
        begin : hangBlk
            int stallHeld;
            stallHeld         = 0;
            MemReadM          = 1'b1;
            FunctM            = 3'b010;
            AddrM             = 32'h0000_0400;
            bus.bus_req_ready = 1'b0;
            for (int c = 0; c < 100; c++) begin
                #1;
                if (StallMemReq) stallHeld++;
                @(negedge clk);
            end
            #1;
            check("hang_stall_cycles", 32'(stallHeld), 32'd100);
            check("hang_req_held", 32'(bus.bus_req_valid), 32'd1);
            bus.bus_req_ready = 1'b1;
            @(negedge clk);
            bus.bus_req_ready = 1'b0;
            bus.bus_rsp_valid = 1'b1;
            bus.bus_err       = 1'b0;
            bus.bus_rdata     = 32'h1122_3344;
            @(negedge clk);
            bus.bus_rsp_valid = 1'b0;
            #1;
            check("hang_release_valid", 32'(LoadValidM), 32'd1);
            check("hang_release_data", LoadDataM, 32'h1122_3344);
            MemReadM = 1'b0;
            @(negedge clk);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
